// File: rtl/adc_scan_if.sv
// Signal bundle between the scan sequencer and its surroundings: ADC pins,
// mux drives and the per-channel result stream.
// Handshake: ch_valid, scan_done and overrun are single-cycle strobes with no
// back-pressure; ch_addr/ch_data are stable from the strobe until the next
// conversion completes, and start is a free-running asynchronous level whose
// rising edge requests one conversion.
interface adc_scan_if #(
  parameter int DATA_W   = 12,
  parameter int MUX_BITS = 3,
  parameter int GROUPS   = 3,
  parameter int ADDR_W   = 5
);
  logic                start;
  logic                adc_sdata;
  logic                adc_ncs;
  logic                adc_sclk;
  logic [MUX_BITS-1:0] mux_sel;
  logic [GROUPS-1:0]   mux_en;
  logic [ADDR_W-1:0]   ch_addr;
  logic [DATA_W-1:0]   ch_data;
  logic                ch_valid;
  logic                scan_done;
  logic                busy;
  logic                overrun;
  logic [1:0]          state_dbg;

  modport master (
    output start, adc_sdata,
    input  adc_ncs, adc_sclk, mux_sel, mux_en, ch_addr, ch_data,
    input  ch_valid, scan_done, busy, overrun, state_dbg
  );

  modport slave (
    input  start, adc_sdata,
    output adc_ncs, adc_sclk, mux_sel, mux_en, ch_addr, ch_data,
    output ch_valid, scan_done, busy, overrun, state_dbg
  );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Analog scan sequencer: steps through CHANNELS mux inputs, lets each settle,
// clocks one serial ADC frame in, and publishes channel address plus result.
module adc_scan_sequencer #(
  parameter int DATA_W        = 12,
  parameter int FRAME_BITS    = 16,
  parameter int CHANNELS      = 24,
  parameter int MUX_BITS      = 3,
  parameter int GROUPS        = 3,
  parameter int ADDR_W        = 5,
  parameter int SETTLE_CYCLES = 10,
  parameter int SCLK_DIV      = 4,
  parameter int INVERT        = 1,
  parameter logic [CHANNELS-1:0] IGNORE_MASK = CHANNELS'(2)
) (
  input  logic      clk,
  input  logic      reset,
  adc_scan_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CONV   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W  = $clog2(FRAME_BITS + 1);
  localparam int MASK_W = 1 << ADDR_W;
  // Mask widened to the full address space so any ch value indexes it safely
  localparam logic [MASK_W-1:0] MASK_EXT = MASK_W'(IGNORE_MASK);

  logic [1:0]        state_q, state_d;
  logic [2:0]        sync_q;
  logic              req;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  // Only the trailing DATA_W bits of a frame are ever used, so the leading
  // framing bits simply fall off the top of this register.
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ncs_q, ncs_d;
  logic              sclk_q, sclk_d;
  logic [ADDR_W-1:0] ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic [GROUPS-1:0] mux_en;

  // Rising edge of the synchronised start level
  assign req = sync_q[1] & ~sync_q[2];

  // Two-flop synchroniser for start plus the edge-detector history flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 3'b000;
    else       sync_q <= {sync_q[1:0], bus.start};
  end

  // Scan FSM next-state logic: settle, clock one frame, publish result
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    ncs_d    = ncs_q;
    sclk_d   = sclk_q;
    ch_d     = ch_q;
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    ovr_d    = req && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d  = ST_SETTLE;
          settle_d = SET_W'(SETTLE_CYCLES - 1);
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_CONV;
          ncs_d   = 1'b0;
          div_d   = DIV_W'(SCLK_DIV - 1);
          bit_d   = '0;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_CONV: begin
        if (div_q == '0) begin
          div_d  = DIV_W'(SCLK_DIV - 1);
          sclk_d = ~sclk_q;
          // Low-to-high SCLK: the ADC put this bit out half a period ago
          if (!sclk_q) begin
            shift_d = {shift_q[DATA_W-2:0], bus.adc_sdata};
            if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
              state_d = ST_DONE;
              ncs_d   = 1'b1;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      default: begin
        addr_d  = ch_q;
        data_d  = (INVERT != 0) ? ~shift_q : shift_q;
        valid_d = ~MASK_EXT[ch_q];
        if (ch_q == ADDR_W'(CHANNELS - 1)) begin
          done_d = 1'b1;
          ch_d   = '0;
        end else begin
          ch_d = ch_q + 1'b1;
        end
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scan FSM state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      ncs_q    <= 1'b1;
      sclk_q   <= 1'b1;
      ch_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      ncs_q    <= ncs_d;
      sclk_q   <= sclk_d;
      ch_q     <= ch_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  // One-hot group enable decoded from the upper channel bits
  always_comb begin
    mux_en = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if ((ch_q >> MUX_BITS) == ADDR_W'(g)) mux_en[g] = 1'b1;
    end
  end

  assign bus.adc_ncs   = ncs_q;
  assign bus.adc_sclk  = sclk_q;
  assign bus.mux_sel   = ch_q[MUX_BITS-1:0];
  assign bus.mux_en    = mux_en;
  assign bus.ch_addr   = addr_q;
  assign bus.ch_data   = data_q;
  assign bus.ch_valid  = valid_q;
  assign bus.scan_done = done_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.overrun   = ovr_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: a default-parameter instance plus a
// small fast configuration, each fed by a behavioural serial ADC.
module tb_adc_scan_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  adc_scan_if #(.DATA_W(12), .MUX_BITS(3), .GROUPS(3), .ADDR_W(5)) if1 ();
  adc_scan_if #(.DATA_W(12), .MUX_BITS(3), .GROUPS(1), .ADDR_W(3)) if2 ();

  adc_scan_sequencer dut (.clk(clk), .reset(reset), .bus(if1));

  adc_scan_sequencer #(
    .INVERT(0), .SCLK_DIV(1), .FRAME_BITS(12), .CHANNELS(5),
    .GROUPS(1), .ADDR_W(3), .IGNORE_MASK(5'b00000)
  ) dut2 (.clk(clk), .reset(reset), .bus(if2));

  int vectors = 0;
  int errors  = 0;

  // ADC models: next bit presented on each SCLK falling edge, MSB first
  logic [15:0] word1 = 16'h0123;
  logic [11:0] word2 = 12'hFFF;
  int idx1 = 0;
  int idx2 = 0;

  always @(negedge if1.adc_ncs) idx1 = 0;
  always @(negedge if1.adc_sclk) begin
    if (!if1.adc_ncs && idx1 < 16) begin
      if1.adc_sdata = word1[15-idx1];
      idx1++;
    end
  end

  always @(negedge if2.adc_ncs) idx2 = 0;
  always @(negedge if2.adc_sclk) begin
    if (!if2.adc_ncs && idx2 < 12) begin
      if2.adc_sdata = word2[11-idx2];
      idx2++;
    end
  end

  // Event counters sampled on the inactive edge
  int v1 = 0, d1 = 0, o1 = 0, nl1 = 0;
  int v2 = 0, d2 = 0, nl2 = 0;
  always @(negedge clk) begin
    if (if1.ch_valid  === 1'b1) v1++;
    if (if1.scan_done === 1'b1) d1++;
    if (if1.overrun   === 1'b1) o1++;
    if (if1.adc_ncs   === 1'b0) nl1++;
    if (if2.ch_valid  === 1'b1) v2++;
    if (if2.scan_done === 1'b1) d2++;
    if (if2.adc_ncs   === 1'b0) nl2++;
  end

  task automatic set_start(input int which, input logic val);
    if (which == 0) if1.start = val;
    else            if2.start = val;
  endtask

  // One request on the chosen instance; returns after the conversion retires
  task automatic run_req(input int which);
    bit seen = 0;
    bit fin = 0;
    logic b;
    @(negedge clk);
    set_start(which, 1'b1);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 4) set_start(which, 1'b0);
      b = (which == 0) ? if1.busy : if2.busy;
      if (b) seen = 1;
      else if (seen) begin
        fin = 1;
        break;
      end
    end
    set_start(which, 1'b0);
    vectors++;
    if (fin !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout dut=%0d got=not_finished exp=finished", which);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (if1.adc_ncs !== 1'b1) begin errors++; $display("FAIL rst_ncs got=%b exp=1", if1.adc_ncs); end
    vectors++; if (if1.adc_sclk !== 1'b1) begin errors++; $display("FAIL rst_sclk got=%b exp=1", if1.adc_sclk); end
    vectors++; if (if1.mux_sel !== 3'd0) begin errors++; $display("FAIL rst_mux_sel got=%0d exp=0", if1.mux_sel); end
    vectors++; if (if1.mux_en !== 3'b001) begin errors++; $display("FAIL rst_mux_en got=%b exp=001", if1.mux_en); end
    vectors++; if (if1.ch_addr !== 5'd0) begin errors++; $display("FAIL rst_ch_addr got=%0d exp=0", if1.ch_addr); end
    vectors++; if (if1.ch_data !== 12'h000) begin errors++; $display("FAIL rst_ch_data got=%h exp=000", if1.ch_data); end
    vectors++; if ({if1.ch_valid, if1.scan_done, if1.overrun} !== 3'b000) begin errors++; $display("FAIL rst_strobes got=%b exp=000", {if1.ch_valid, if1.scan_done, if1.overrun}); end
    vectors++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", if1.busy); end
    vectors++; if (if1.state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", if1.state_dbg); end
    vectors++; if (if2.adc_ncs !== 1'b1) begin errors++; $display("FAIL rst_ncs2 got=%b exp=1", if2.adc_ncs); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Channel 0: cycle-exact latency from the start edge
  task automatic test_timing();
    int n = 0;
    int m = 0;
    int hi = 0;
    @(negedge clk);
    if1.start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (if1.adc_ncs === 1'b0) break;
    end
    if1.start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      m++;
      if (hi == 0 && if1.adc_ncs === 1'b1) hi = m;
      if (if1.ch_valid === 1'b1) break;
    end
    vectors++; if (n != 13) begin errors++; $display("FAIL ncs_fall_latency got=%0d exp=13", n); end
    vectors++; if (hi != 128) begin errors++; $display("FAIL ncs_low_len got=%0d exp=128", hi); end
    vectors++; if (m != 129) begin errors++; $display("FAIL valid_latency got=%0d exp=129", m); end
    vectors++; if (if1.ch_addr !== 5'd0) begin errors++; $display("FAIL ch0_addr got=%0d exp=0", if1.ch_addr); end
    vectors++; if (if1.ch_data !== 12'hEDC) begin errors++; $display("FAIL ch0_data got=%h exp=edc", if1.ch_data); end
    vectors++; if (if1.mux_sel !== 3'd1) begin errors++; $display("FAIL ch0_mux_sel got=%0d exp=1", if1.mux_sel); end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Channels 1 (masked) and 2
  task automatic test_mask();
    int vb;
    vb = v1;
    run_req(0);
    vectors++; if (v1 - vb != 0) begin errors++; $display("FAIL ch1_valid_count got=%0d exp=0", v1 - vb); end
    vectors++; if (if1.ch_addr !== 5'd1) begin errors++; $display("FAIL ch1_addr got=%0d exp=1", if1.ch_addr); end
    vectors++; if (if1.ch_data !== 12'hEDC) begin errors++; $display("FAIL ch1_data got=%h exp=edc", if1.ch_data); end
    vectors++; if (if1.mux_sel !== 3'd2) begin errors++; $display("FAIL ch1_mux_sel got=%0d exp=2", if1.mux_sel); end
    vb = v1;
    run_req(0);
    vectors++; if (v1 - vb != 1) begin errors++; $display("FAIL ch2_valid_count got=%0d exp=1", v1 - vb); end
    vectors++; if (if1.ch_addr !== 5'd2) begin errors++; $display("FAIL ch2_addr got=%0d exp=2", if1.ch_addr); end
    vectors++; if (if1.mux_sel !== 3'd3) begin errors++; $display("FAIL ch2_mux_sel got=%0d exp=3", if1.mux_sel); end
  endtask

  // Full 24-channel scan from reset: group enables and the single scan_done
  task automatic test_full_scan();
    int db;
    int d0;
    logic [2:0] exp_en;
    d0 = d1;
    for (int i = 0; i < 24; i++) begin
      db = d1;
      run_req(0);
      exp_en = 3'b001 << (((i + 1) % 24) / 8);
      vectors++; if (if1.ch_addr !== 5'(i)) begin errors++; $display("FAIL scan_addr i=%0d got=%0d exp=%0d", i, if1.ch_addr, i); end
      vectors++; if (if1.mux_en !== exp_en) begin errors++; $display("FAIL scan_mux_en i=%0d got=%b exp=%b", i, if1.mux_en, exp_en); end
      vectors++; if (d1 - db != ((i == 23) ? 1 : 0)) begin errors++; $display("FAIL scan_done_at i=%0d got=%0d exp=%0d", i, d1 - db, (i == 23) ? 1 : 0); end
    end
    vectors++; if (d1 - d0 != 1) begin errors++; $display("FAIL scan_done_total got=%0d exp=1", d1 - d0); end
  endtask

  // Second start edge 50 cycles into a conversion is dropped
  task automatic test_overrun();
    int vb, ob, nb;
    bit fin = 0;
    vb = v1; ob = o1; nb = nl1;
    @(negedge clk);
    if1.start = 1'b1;
    repeat (4) @(negedge clk);
    if1.start = 1'b0;
    repeat (46) @(negedge clk);
    if1.start = 1'b1;
    repeat (4) @(negedge clk);
    if1.start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (if1.busy === 1'b0) begin fin = 1; break; end
    end
    repeat (20) @(negedge clk);
    vectors++; if (fin !== 1'b1) begin errors++; $display("FAIL ovr_timeout got=busy exp=idle"); end
    vectors++; if (o1 - ob != 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", o1 - ob); end
    vectors++; if (nl1 - nb != 128) begin errors++; $display("FAIL ovr_ncs_low got=%0d exp=128", nl1 - nb); end
    vectors++; if (v1 - vb != 1) begin errors++; $display("FAIL ovr_valid_count got=%0d exp=1", v1 - vb); end
    vectors++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL ovr_busy_after got=%b exp=0", if1.busy); end
  endtask

  // Reset at SCLK rising edge 7 aborts cleanly; next scan restarts at channel 0
  task automatic test_reset_mid_conv();
    int vb;
    int rises = 0;
    logic prev = 1'b1;
    vb = v1;
    @(negedge clk);
    if1.start = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 4) if1.start = 1'b0;
      if (if1.adc_ncs === 1'b0 && if1.adc_sclk === 1'b1 && prev === 1'b0) rises++;
      prev = if1.adc_sclk;
      if (rises == 7) break;
    end
    if1.start = 1'b0;
    vectors++; if (rises != 7) begin errors++; $display("FAIL midrst_reach got=%0d exp=7", rises); end
    reset = 1'b1;
    #1;
    vectors++; if (if1.adc_ncs !== 1'b1) begin errors++; $display("FAIL midrst_ncs got=%b exp=1", if1.adc_ncs); end
    vectors++; if (if1.adc_sclk !== 1'b1) begin errors++; $display("FAIL midrst_sclk got=%b exp=1", if1.adc_sclk); end
    vectors++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", if1.busy); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (v1 - vb != 0) begin errors++; $display("FAIL midrst_valid got=%0d exp=0", v1 - vb); end
    run_req(0);
    vectors++; if (if1.ch_addr !== 5'd0) begin errors++; $display("FAIL midrst_next_addr got=%0d exp=0", if1.ch_addr); end
    vectors++; if (v1 - vb != 1) begin errors++; $display("FAIL midrst_next_valid got=%0d exp=1", v1 - vb); end
    vectors++; if (if1.ch_data !== 12'hEDC) begin errors++; $display("FAIL midrst_next_data got=%h exp=edc", if1.ch_data); end
  endtask

  // Small config: no inversion, 12-bit frame, SCLK_DIV=1, 5 channels
  task automatic test_small_config();
    int vb, db, nb;
    for (int i = 0; i < 5; i++) begin
      vb = v2; db = d2; nb = nl2;
      run_req(1);
      vectors++; if (if2.ch_data !== 12'hFFF) begin errors++; $display("FAIL small_data i=%0d got=%h exp=fff", i, if2.ch_data); end
      vectors++; if (if2.ch_addr !== 3'(i)) begin errors++; $display("FAIL small_addr i=%0d got=%0d exp=%0d", i, if2.ch_addr, i); end
      vectors++; if (nl2 - nb != 24) begin errors++; $display("FAIL small_ncs_low i=%0d got=%0d exp=24", i, nl2 - nb); end
      vectors++; if (v2 - vb != 1) begin errors++; $display("FAIL small_valid i=%0d got=%0d exp=1", i, v2 - vb); end
      vectors++; if (d2 - db != ((i == 4) ? 1 : 0)) begin errors++; $display("FAIL small_scan_done i=%0d got=%0d exp=%0d", i, d2 - db, (i == 4) ? 1 : 0); end
    end
  endtask

  initial begin
    if1.start = 1'b0; if1.adc_sdata = 1'b0;
    if2.start = 1'b0; if2.adc_sdata = 1'b0;
    #1 reset = 1'b1;
    test_reset();
    test_timing();
    test_mask();
    test_reset();
    test_full_scan();
    test_overrun();
    test_reset_mid_conv();
    test_small_config();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Parametrised successor to the fixed 3×8 analog mux switcher and SPI ADC receiver pair. It is a single-clock block that scans CHANNELS analog inputs through 2^MUX_BITS-way multiplexer groups. Per channel it drives the mux select and group enable, waits a settling time, reads one serial ADC frame, and emits the channel address and data with a valid strobe. It sits between the ADC pins and the analog distributor/FIFO in the analog path.

## Interface
- DATA_W, 12: ADC result width.
- FRAME_BITS, 16: SCLK periods per ADC frame; result is the last DATA_W bits shifted in. Must be ≥ DATA_W.
- CHANNELS, 24: channels per scan, 1..2^ADDR_W.
- MUX_BITS, 3: select width per mux group.
- GROUPS, 3: mux groups, equal to ceil(CHANNELS / 2^MUX_BITS).
- ADDR_W, 5: channel address width.
- SETTLE_CYCLES, 10: clk cycles between mux change and nCS fall, ≥1.
- SCLK_DIV, 4: clk cycles per SCLK half-period, ≥1.
- INVERT, 1: 1 → output (2^DATA_W−1) − sample; 0 → raw sample.
- IGNORE_MASK, 1 (bit 1 set): bit c=1 converts channel c but suppresses ch_valid.
- clk  in  1  system clock (80 MHz).
- reset  in  1  asynchronous, active-high.
- start  in  1  conversion request, asynchronous (PLL-derived clock); the rising edge is used.
- adc_sdata  in  1  ADC serial data.
- adc_ncs  out  1  ADC chip select, active-low.
- adc_sclk  out  1  ADC serial clock, idle high.
- mux_sel  out  MUX_BITS  select, shared by all groups.
- mux_en  out  GROUPS  one-hot group enable.
- ch_addr  out  ADDR_W  channel of current ch_data.
- ch_data  out  DATA_W  conversion result.
- ch_valid  out  1  one-cycle strobe.
- scan_done  out  1  one-cycle strobe, last channel completed.
- busy  out  1  high outside IDLE.
- overrun  out  1  one-cycle strobe, request dropped.

## Operation
- start passes through a 2-flop synchroniser, then a rising-edge detector (third flop). The detected edge is `req`.
- Channel index `ch` runs 0..CHANNELS−1 and wraps to 0. Outputs follow it: mux_sel = ch mod 2^MUX_BITS; mux_en = one-hot(ch / 2^MUX_BITS).
- mux_sel and mux_en are updated in the cycle `ch` changes, at the end of DONE. The next channel is therefore already settling while the block waits in IDLE.
- States:
  - IDLE: on `req` go to SETTLE and load the settle counter with SETTLE_CYCLES−1.
  - SETTLE: count down to 0, then go to CONV with adc_ncs=0.
  - CONV: adc_sclk toggles every SCLK_DIV cycles. The first toggle (high→low) comes SCLK_DIV cycles after nCS falls. On each low→high toggle, adc_sdata is sampled into an FRAME_BITS-bit shift register, MSB first. After the FRAME_BITS-th rising edge go to DONE; SCLK stays high.
  - DONE (1 cycle): adc_ncs=1. Register ch_data from the low DATA_W bits of the shift register, with INVERT applied, and set ch_addr=ch. Pulse ch_valid unless IGNORE_MASK[ch]. If ch==CHANNELS−1, pulse scan_done and set ch=0; otherwise ch=ch+1. Go to IDLE.
- `req` outside IDLE: the request is dropped, overrun pulses for one cycle, and state is unaffected.
- Reset values: adc_ncs=1, adc_sclk=1, ch=0, mux_sel=0, mux_en=1 (group 0), ch_addr=0, ch_data=0, all strobes 0, busy=0, state IDLE, synchroniser flops 0.
- Reset asserted mid-conversion aborts immediately to these values with no partial ch_valid. The first scan after release starts at channel 0.

## Timing
- start edge to `req`: 3 clk cycles.
- `req` to adc_ncs low: SETTLE_CYCLES cycles.
- nCS low duration: 2·SCLK_DIV·FRAME_BITS cycles (128 at defaults).
- ch_valid: asserted in the cycle after adc_ncs returns high. Total `req`→ch_valid = SETTLE_CYCLES + 2·SCLK_DIV·FRAME_BITS + 1 (139 at defaults).
- ch_data and ch_addr hold until the next DONE.
- Minimum request spacing without overrun: the latency above plus 1 cycle.
- The ADC must present each bit on the SCLK falling edge; the block samples it SCLK_DIV cycles later.

## Test plan
- Reset, then 3 requests. ADC model returns 0x0000 framing + 12'h123. Required: ch_addr=0,1,2; ch_data=12'hEDC (INVERT); ch_valid on channels 0 and 2 only (channel 1 masked); mux_sel=1,2,3 after each DONE.
- 24 requests (defaults): exactly one scan_done, coincident with DONE for ch_addr=23. mux_en sequence 001→010→100→001 at channels 8, 16 and the wrap.
- Request edge arriving 50 cycles after the previous one: one-cycle overrun; adc_ncs stays low through the original 128 cycles; exactly one ch_valid.
- Assert reset at SCLK rising edge 7 of a conversion: adc_ncs=1 and adc_sclk=1 immediately; no ch_valid. After release the next request converts channel 0.
- INVERT=0, SCLK_DIV=1, FRAME_BITS=12, CHANNELS=5, ADC value 12'hFFF: ch_data=12'hFFF; nCS low exactly 24 cycles; scan_done after the 5th request.
- Check cycle counts at defaults: adc_ncs falls 13 clk cycles after the start edge; ch_valid follows 129 cycles after adc_ncs falls (128 cycles low + 1 DONE cycle).
